// File: rtl/icache_sa.sv
// Set-associative instruction cache: same-cycle hits, word-serial refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        hit,
    output logic [31:0] inst_out,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(SETS);
    localparam int OFFW = (OFF > 0) ? OFF : 1;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAGW = 30 - IDX - OFF;
    localparam logic [OFFW-1:0] LAST = OFFW'(LINE_WORDS - 1);
    localparam logic [31:0] BASE_MASK = ~32'(LINE_WORDS * 4 - 1);

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t r_state, w_next;

    logic [31:0]     r_data [WAYS][SETS][LINE_WORDS];
    logic [TAGW-1:0] r_tag  [WAYS][SETS];
    logic [SETS-1:0] r_valid [WAYS];
    logic [WB-1:0]   r_rr [SETS];

    logic            r_fpend;
    logic            r_mem_req;
    logic [31:0]     r_mem_addr;
    logic [OFFW-1:0] r_k;
    logic [WB-1:0]   r_vic;
    logic [IDX-1:0]  r_ridx;
    logic [TAGW-1:0] r_rtag;

    logic [29:0]     w_wa;
    logic [OFFW-1:0] w_off;
    logic [IDX-1:0]  w_idx;
    logic [TAGW-1:0] w_tag;
    logic            w_any;
    logic [WB-1:0]   w_way;
    logic            w_inv;
    logic [WB-1:0]   w_vic;
    logic [WB-1:0]   w_rr_nxt;
    logic            w_hit;
    logic            w_start;
    logic            w_done;
    logic            w_unused;

    assign w_wa     = pc[31:2];
    assign w_off    = OFFW'(w_wa) & LAST;
    assign w_idx    = IDX'(w_wa >> OFF);
    assign w_tag    = TAGW'(w_wa >> (OFF + IDX));
    assign w_unused = &{1'b0, pc[1:0]};

    always_comb begin
        w_any = 1'b0;
        w_way = '0;
        w_inv = 1'b0;
        w_vic = r_rr[w_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_any = 1'b1;
                w_way = WB'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w][w_idx]) begin
                w_inv = 1'b1;
                w_vic = WB'(w);
            end
        end
    end

    assign w_rr_nxt = (r_rr[w_idx] == WB'(WAYS - 1)) ? '0
                    : r_rr[w_idx] + 1'b1;

    assign w_hit    = w_any && (r_state == S_IDLE) && !r_fpend && !flush;
    assign hit      = w_hit;
    assign inst_out = w_hit ? r_data[w_way][w_idx][w_off] : '0;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (pc_valid && !w_any && !flush && !r_fpend) begin
                    w_start = 1'b1;
                    w_next  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_rdy && r_k == LAST) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else if (rdy) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            r_fpend    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_k        <= '0;
            r_vic      <= '0;
            r_ridx     <= '0;
            r_rtag     <= '0;
        end else if (rdy) begin
            if (r_state == S_IDLE && (flush || r_fpend)) begin
                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
                r_fpend <= 1'b0;
            end
            if (r_state == S_REFILL && flush) begin
                r_fpend <= 1'b1;
            end
            if (w_start) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= pc & BASE_MASK;
                r_k        <= '0;
                r_vic      <= w_vic;
                r_ridx     <= w_idx;
                r_rtag     <= w_tag;
                if (!w_inv) r_rr[w_idx] <= w_rr_nxt;
            end
            if (r_state == S_REFILL && mem_rdy) begin
                if (w_done) begin
                    r_mem_req <= 1'b0;
                    // A flush seen during the refill leaves the line invalid.
                    if (!r_fpend && !flush) r_valid[r_vic][r_ridx] <= 1'b1;
                end else begin
                    r_k        <= r_k + 1'b1;
                    r_mem_addr <= r_mem_addr + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && r_state == S_REFILL && mem_rdy) begin
            r_data[r_vic][r_ridx][r_k] <= mem_data;
            if (w_done) r_tag[r_vic][r_ridx] <= r_rtag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy) begin
            if (r_state == S_IDLE && pc_valid && w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_start) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache sitting between IFetch and the memory controller. It serves hits combinationally in the same cycle as the fetch address. On a miss it refills a multi-word line through a word-at-a-time handshake with the memory controller. It adds round-robin replacement, a whole-cache flush for fence.i and optional performance counters.

## Interface
- `WAYS`, 2, associativity; must be 1, 2 or 4.
- `SETS`, 64, sets per way; power of two, ≥2.
- `LINE_WORDS`, 4, 32-bit words per line; power of two, ≥1.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low; `rst==0` at a rising edge resets the block.
- `rdy` in 1: global ready; when 0 all state, counters and outputs hold.
- `pc` in 32: fetch address; bits [1:0] ignored.
- `pc_valid` in 1: IFetch is requesting `pc` this cycle.
- `hit` out 1: combinational; `pc` is resident, no flush is pending and the state is IDLE.
- `inst_out` out 32: combinational word for `pc` when `hit`, else 0.
- `flush` in 1: single-cycle pulse that invalidates the whole cache.
- `mem_req` out 1: refill in progress.
- `mem_addr` out 32: word address currently requested.
- `mem_rdy` in 1: `mem_data` is valid for `mem_addr` this cycle.
- `mem_data` in 32: refill word.
- `hit_cnt` out 32: performance counter (see Configuration).
- `miss_cnt` out 32: performance counter (see Configuration).

## Operation
- Address split:
  - OFF = log2(LINE_WORDS); IDX = log2(SETS).
  - Word offset = `pc[OFF+1:2]`; index = `pc[IDX+OFF+1:OFF+2]`; tag = `pc[31:IDX+OFF+2]`.
- Storage per way and set: valid bit, tag, LINE_WORDS data words. Per set: a round-robin pointer of log2(WAYS) bits.
- States: IDLE and REFILL.
- **IDLE**
  - `pc_valid && !hit` (with `rdy`) moves to REFILL and latches line base = `pc` with the offset bits and bits [1:0] zeroed.
  - It also latches the index and tag, selects the victim way, clears the word counter, and sets `mem_req=1`, `mem_addr`=line base.
- **Victim selection:** lowest-numbered invalid way in the set. If every way is valid, take the set's round-robin pointer and then increment the pointer modulo WAYS. With WAYS=1 the victim is always way 0.
- **REFILL**
  - Each cycle with `mem_rdy=1` writes `mem_data` into the victim at word counter k, then increments k and `mem_addr` by 4.
  - After word LINE_WORDS−1 is written:
    - set the victim's valid bit and tag;
    - drop `mem_req` to 0;
    - return to IDLE.
  - `mem_req` stays high continuously between those points. `mem_addr` is only ever the line base plus 4·k.
- **`pc` change during REFILL** (for example a branch redirect): the latched line still completes and is installed; `hit` stays 0 until IDLE.
- **Flush**
  - In IDLE, flush clears every valid bit and every round-robin pointer on the next edge; `hit`=0 in the cycle `flush` is high.
  - During REFILL, flush is recorded as pending. The refill runs to completion, but the line is not validated. On return to IDLE all valid bits clear, and then the pending flag clears.
  - Flush and a miss in the same IDLE cycle: the flush wins and no refill starts.
- **Reset**, including mid-refill:
  - state IDLE, all valid bits 0, pointers 0, pending flush 0;
  - `mem_req=0`, `mem_addr=0`, `hit_cnt=0`, `miss_cnt=0`;
  - data and tag arrays are not cleared.

## Timing
- Hit latency 0: `hit`/`inst_out` follow `pc` combinationally in IDLE.
- Miss penalty = 1 (IDLE→REFILL) + LINE_WORDS accepted words. The first `hit` for the missed `pc` appears in the first IDLE cycle after the last `mem_rdy`.
- `mem_rdy` gaps are legal; each `mem_rdy` cycle transfers exactly one word.
- `rdy=0` freezes the state, the word counter, `mem_addr` and the counters. A `mem_rdy` arriving while `rdy=0` is ignored, so the memory controller must hold it.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `hit_cnt` increments on each `rdy` cycle in IDLE with `pc_valid && hit`;
  - `miss_cnt` increments on each IDLE→REFILL transition;
  - both wrap modulo 2^32.
- `ICACHE_PERF_EN` undefined: both outputs are constant 0 and no counter registers exist.

## Test plan
- Cold miss, WAYS=2, LINE_WORDS=4: pc=0x100 with `pc_valid` → `mem_req` rises next cycle. `mem_addr` steps 0x100, 0x104, 0x108, 0x10C on `mem_rdy`, `mem_req` falls, then `hit=1` and `inst_out`= the word returned at 0x100. pc=0x10C then hits with the 4th word.
- Conflict, SETS=64, LINE_WORDS=4 (set stride 0x400): fill 0x000 then 0x400, both hit. 0x800 evicts way 0 (0x000), then 0xC00 evicts way 1 (0x400). 0x800 and 0xC00 hit; 0x000 and 0x400 miss.
- Flush in IDLE after filling 0x100 → next cycle pc=0x100 misses and `mem_addr`=0x100.
- Flush during REFILL of 0x200 → refill completes (4 words) but 0x200 misses again afterwards; no other line hits.
- Reset with `rst=0` after 2 of 4 refill words → `mem_req=0`, `mem_addr=0`, state IDLE; a refetch of the same pc restarts from the line base.
- `rdy=0` for 3 cycles mid-refill with `mem_rdy` held high → no word advance. With ICACHE_PERF_EN defined, after one miss plus 5 hit cycles: `miss_cnt=1`, `hit_cnt=5`.
